// File: rtl/aexm_pkg.sv
// Shared definitions for the pipeline enable unit: FSM state encoding,
// default parameter values and the channel-select width helper.
package aexm_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_I_WAIT   = 2'd1,
        ST_MEM_REQ  = 2'd2,
        ST_MEM_WAIT = 2'd3
    } state_e;

    localparam int NCH_DEF    = 2;
    localparam int WAIT_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;

    // A single channel still needs a one-bit select port.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/aexm_enable_nport_if.sv
// Bundle between the pipeline/cache side (master) and the enable unit (slave).
interface aexm_enable_nport_if
    import aexm_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    localparam int SEL_W = sel_width(NCH);

    logic             icache_busy;
    logic [NCH-1:0]   dcache_busy;
    logic             dSTRLOD;
    logic             dLOD;
    logic             dSKIP;
    logic             fSTALL;
    logic [SEL_W-1:0] dCH_SEL;

    logic             cpu_enable;
    logic             icache_enable;
    logic [NCH-1:0]   dcache_enable;
    logic             cpu_mode_memop;
    logic             mem_is_load;
    logic             timeout_err;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output icache_busy, dcache_busy, dSTRLOD, dLOD, dSKIP, fSTALL, dCH_SEL,
        input  cpu_enable, icache_enable, dcache_enable, cpu_mode_memop,
               mem_is_load, timeout_err, stall_cnt
    );

    modport slave (
        input  icache_busy, dcache_busy, dSTRLOD, dLOD, dSKIP, fSTALL, dCH_SEL,
        output cpu_enable, icache_enable, dcache_enable, cpu_mode_memop,
               mem_is_load, timeout_err, stall_cnt
    );

endinterface

// File: rtl/aexm_enable_core.sv
// Enable FSM: stalls the pipeline for i-cache misses and sequences one
// data-cache access per load/store on the selected channel.
module aexm_enable_core
    import aexm_pkg::*;
#(
    parameter int NCH    = NCH_DEF,
    parameter int WAIT_W = WAIT_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                gclk,
    input  logic                grst,
    aexm_enable_nport_if.slave  bus
);
    localparam int SEL_W = sel_width(NCH);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [SEL_W-1:0] r_ch;
    logic             r_load;
    logic             r_guard;
    logic             r_timeout;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [SEL_W-1:0] w_ch_sel;
    logic [NCH-1:0]   w_ch_onehot;
    logic             w_ch_busy;
    logic             w_cpu_en;
    logic             w_ic_en;
    logic [NCH-1:0]   w_dc_en;
    logic             w_mode;
    logic             w_latch;
    logic             w_guard_set;
    logic             w_wait_clr;
    logic             w_wait_inc;
    logic             w_sat;

    // Out-of-range channel numbers fall back to channel 0.
    assign w_ch_sel    = (int'(bus.dCH_SEL) < NCH) ? bus.dCH_SEL : '0;
    assign w_ch_onehot = NCH'(1) << r_ch;
    // Only the busy line of the channel being served matters.
    assign w_ch_busy   = |(bus.dcache_busy & w_ch_onehot);

    aexm_sat_counter #(
        .WIDTH (WAIT_W)
    ) u_wait_cnt (
        .gclk  (gclk),
        .grst  (grst),
        .i_clr (w_wait_clr),
        .i_inc (w_wait_inc),
        .o_sat (w_sat)
    );

    // Next-state and enable decode; reset overrides every output.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned and no latch is inferred.
        w_state_nxt = r_state;
        w_cpu_en    = 1'b1;
        w_ic_en     = 1'b1;
        w_dc_en     = '0;
        w_mode      = 1'b0;
        w_latch     = 1'b0;
        w_guard_set = 1'b0;
        w_wait_clr  = 1'b0;
        w_wait_inc  = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (bus.icache_busy) begin
                    // I-cache miss wins even if a memop is waiting in decode.
                    w_cpu_en    = 1'b0;
                    w_ic_en     = 1'b0;
                    w_wait_clr  = 1'b1;
                    w_state_nxt = ST_I_WAIT;
                end else if (bus.dSTRLOD && !bus.dSKIP && !r_guard) begin
                    w_cpu_en    = 1'b0;
                    w_ic_en     = 1'b0;
                    w_latch     = 1'b1;
                    w_state_nxt = ST_MEM_REQ;
                end else begin
                    w_ic_en = !bus.fSTALL;
                end
            end
            ST_I_WAIT: begin
                w_cpu_en   = 1'b0;
                w_ic_en    = 1'b0;
                w_wait_inc = 1'b1;
                if (!bus.icache_busy) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_MEM_REQ: begin
                w_cpu_en    = 1'b0;
                w_ic_en     = 1'b0;
                w_dc_en     = w_ch_onehot;
                w_mode      = 1'b1;
                w_wait_clr  = 1'b1;
                w_state_nxt = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                w_cpu_en   = 1'b0;
                w_ic_en    = 1'b0;
                w_mode     = 1'b1;
                w_wait_inc = 1'b1;
                if (!w_ch_busy) begin
                    // The memop is still in decode on the next cycle; the guard
                    // lets it advance instead of being started a second time.
                    w_guard_set = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase

        if (grst) begin
            w_cpu_en    = 1'b1;
            w_ic_en     = 1'b1;
            w_dc_en     = '0;
            w_mode      = 1'b0;
            w_latch     = 1'b0;
            w_guard_set = 1'b0;
            w_wait_clr  = 1'b0;
            w_wait_inc  = 1'b0;
        end
    end

    // State register plus the memop latch, guard, sticky timeout and stall count.
    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            r_state     <= ST_RUN;
            r_ch        <= '0;
            r_load      <= 1'b0;
            r_guard     <= 1'b0;
            r_timeout   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_guard   <= w_guard_set;
            r_timeout <= r_timeout | w_sat;
            if (w_latch) begin
                r_ch   <= w_ch_sel;
                r_load <= bus.dLOD;
            end
            if (!w_cpu_en) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.cpu_enable     = w_cpu_en;
    assign bus.icache_enable  = w_ic_en;
    assign bus.dcache_enable  = w_dc_en;
    assign bus.cpu_mode_memop = w_mode;
    assign bus.mem_is_load    = r_load;
    // Visible on the same edge the wait counter saturates, then held.
    assign bus.timeout_err    = r_timeout | w_sat;
    assign bus.stall_cnt      = r_stall_cnt;

endmodule

// File: rtl/aexm_sat_counter.sv
// Saturating up-counter used to time how long the pipeline has been waiting.
module aexm_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic gclk,
    input  logic grst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_sat
);
    logic [WIDTH-1:0] r_count;

    assign o_sat = &r_count;

    // Clear has priority; once all-ones the count holds until cleared.
    always_ff @(posedge gclk or posedge grst) begin
        // NOTE: non-blocking assignments in clocked blocks so every register
        // samples pre-edge values regardless of process evaluation order.
        if (grst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !o_sat) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/aexm_enable_nport.sv
// Pipeline enable unit top: flat pipeline-facing ports, bundled internally
// onto the enable interface that feeds the control core.
module aexm_enable_nport
    import aexm_pkg::*;
#(
    parameter int NCH    = NCH_DEF,
    parameter int WAIT_W = WAIT_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                        gclk,
    input  logic                        grst,
    input  logic                        icache_busy,
    input  logic [NCH-1:0]              dcache_busy,
    input  logic                        dSTRLOD,
    input  logic                        dLOD,
    input  logic                        dSKIP,
    input  logic                        fSTALL,
    input  logic [sel_width(NCH)-1:0]   dCH_SEL,
    output logic                        cpu_enable,
    output logic                        icache_enable,
    output logic [NCH-1:0]              dcache_enable,
    output logic                        cpu_mode_memop,
    output logic                        mem_is_load,
    output logic                        timeout_err,
    output logic [CNT_W-1:0]            stall_cnt
);
    aexm_enable_nport_if #(
        .NCH   (NCH),
        .CNT_W (CNT_W)
    ) u_bus ();

    assign u_bus.icache_busy = icache_busy;
    assign u_bus.dcache_busy = dcache_busy;
    assign u_bus.dSTRLOD     = dSTRLOD;
    assign u_bus.dLOD        = dLOD;
    assign u_bus.dSKIP       = dSKIP;
    assign u_bus.fSTALL      = fSTALL;
    assign u_bus.dCH_SEL     = dCH_SEL;

    aexm_enable_core #(
        .NCH    (NCH),
        .WAIT_W (WAIT_W),
        .CNT_W  (CNT_W)
    ) u_core (
        .gclk (gclk),
        .grst (grst),
        .bus  (u_bus.slave)
    );

    assign cpu_enable     = u_bus.cpu_enable;
    assign icache_enable  = u_bus.icache_enable;
    assign dcache_enable  = u_bus.dcache_enable;
    assign cpu_mode_memop = u_bus.cpu_mode_memop;
    assign mem_is_load    = u_bus.mem_is_load;
    assign timeout_err    = u_bus.timeout_err;
    assign stall_cnt      = u_bus.stall_cnt;

endmodule

// File: tb/tb_aexm_enable_nport.sv
// Bench for aexm_enable_nport: instance A (NCH=2, WAIT_W=8, CNT_W=16) and
// instance B (NCH=3, WAIT_W=3, CNT_W=4). Expected dcache pulses go into a
// per-instance queue; negedge monitors pop and compare them.
module tb_aexm_enable_nport;

    typedef struct {
        logic [7:0] en;
        logic       ld;
    } exp_t;

    logic gclk  = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a;
    exp_t e_b;

    logic low_a   = 1'b0;
    logic low_b   = 1'b0;
    int   model_a = 0;
    int   model_b = 0;

    always #5 gclk = ~gclk;

    aexm_enable_nport_if #(.NCH(2), .CNT_W(16)) bus_a ();
    aexm_enable_nport_if #(.NCH(3), .CNT_W(4))  bus_b ();

    aexm_enable_nport #(.NCH(2), .WAIT_W(8), .CNT_W(16)) dut_a (
        .gclk           (gclk),
        .grst           (rst_a),
        .icache_busy    (bus_a.icache_busy),
        .dcache_busy    (bus_a.dcache_busy),
        .dSTRLOD        (bus_a.dSTRLOD),
        .dLOD           (bus_a.dLOD),
        .dSKIP          (bus_a.dSKIP),
        .fSTALL         (bus_a.fSTALL),
        .dCH_SEL        (bus_a.dCH_SEL),
        .cpu_enable     (bus_a.cpu_enable),
        .icache_enable  (bus_a.icache_enable),
        .dcache_enable  (bus_a.dcache_enable),
        .cpu_mode_memop (bus_a.cpu_mode_memop),
        .mem_is_load    (bus_a.mem_is_load),
        .timeout_err    (bus_a.timeout_err),
        .stall_cnt      (bus_a.stall_cnt)
    );

    aexm_enable_nport #(.NCH(3), .WAIT_W(3), .CNT_W(4)) dut_b (
        .gclk           (gclk),
        .grst           (rst_b),
        .icache_busy    (bus_b.icache_busy),
        .dcache_busy    (bus_b.dcache_busy),
        .dSTRLOD        (bus_b.dSTRLOD),
        .dLOD           (bus_b.dLOD),
        .dSKIP          (bus_b.dSKIP),
        .fSTALL         (bus_b.fSTALL),
        .dCH_SEL        (bus_b.dCH_SEL),
        .cpu_enable     (bus_b.cpu_enable),
        .icache_enable  (bus_b.icache_enable),
        .dcache_enable  (bus_b.dcache_enable),
        .cpu_mode_memop (bus_b.cpu_mode_memop),
        .mem_is_load    (bus_b.mem_is_load),
        .timeout_err    (bus_b.timeout_err),
        .stall_cnt      (bus_b.stall_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge gclk);
        #1;
    endtask

    task automatic mid();
        @(negedge gclk);
    endtask

    // Scoreboard monitor for instance A: every dcache_enable pulse must match the queue head.
    always @(negedge gclk) begin
        if (bus_a.dcache_enable != '0) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_dcache_enable", 32'(bus_a.dcache_enable), 32'd0);
            end else begin
                e_a = q_a.pop_front();
                check("a_dcache_enable", 32'(bus_a.dcache_enable), 32'(e_a.en));
                check("a_pulse_mem_is_load", 32'(bus_a.mem_is_load), 32'(e_a.ld));
                check("a_pulse_memop", 32'(bus_a.cpu_mode_memop), 32'd1);
            end
        end
    end

    // Scoreboard monitor for instance B.
    always @(negedge gclk) begin
        if (bus_b.dcache_enable != '0) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_dcache_enable", 32'(bus_b.dcache_enable), 32'd0);
            end else begin
                e_b = q_b.pop_front();
                check("b_dcache_enable", 32'(bus_b.dcache_enable), 32'(e_b.en));
                check("b_pulse_mem_is_load", 32'(bus_b.mem_is_load), 32'(e_b.ld));
            end
        end
    end

    // Independent stall-cycle model: sample cpu_enable mid-cycle, count at the edge.
    always @(negedge gclk) begin
        low_a <= !rst_a && !bus_a.cpu_enable;
        low_b <= !rst_b && !bus_b.cpu_enable;
    end

    always @(posedge gclk or posedge rst_a) begin
        if (rst_a)      model_a <= 0;
        else if (low_a) model_a <= model_a + 1;
    end

    always @(posedge gclk or posedge rst_b) begin
        if (rst_b)      model_b <= 0;
        else if (low_b) model_b <= model_b + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        // Under reset, drive hostile inputs: outputs must still show reset values.
        bus_a.icache_busy = 1'b1; bus_a.dcache_busy = '0; bus_a.dSTRLOD = 1'b1;
        bus_a.dLOD = 1'b1; bus_a.dSKIP = 1'b0; bus_a.fSTALL = 1'b1; bus_a.dCH_SEL = '0;
        bus_b.icache_busy = 1'b0; bus_b.dcache_busy = '0; bus_b.dSTRLOD = 1'b0;
        bus_b.dLOD = 1'b0; bus_b.dSKIP = 1'b0; bus_b.fSTALL = 1'b0; bus_b.dCH_SEL = '0;
        repeat (2) cyc();
        mid();
        check("rst_cpu_enable",     32'(bus_a.cpu_enable), 32'd1);
        check("rst_icache_enable",  32'(bus_a.icache_enable), 32'd1);
        check("rst_dcache_enable",  32'(bus_a.dcache_enable), 32'd0);
        check("rst_cpu_mode_memop", 32'(bus_a.cpu_mode_memop), 32'd0);
        check("rst_mem_is_load",    32'(bus_a.mem_is_load), 32'd0);
        check("rst_timeout_err",    32'(bus_a.timeout_err), 32'd0);
        check("rst_stall_cnt",      32'(bus_a.stall_cnt), 32'd0);

        cyc();
        bus_a.icache_busy = 1'b0; bus_a.dSTRLOD = 1'b0; bus_a.dLOD = 1'b0; bus_a.fSTALL = 1'b0;
        rst_a = 1'b0; rst_b = 1'b0;
        mid();
        check("idle_cpu_enable", 32'(bus_a.cpu_enable), 32'd1);

        // Annulled memop is ignored; fSTALL only gates the i-cache enable.
        cyc(); bus_a.dSTRLOD = 1'b1; bus_a.dSKIP = 1'b1;
        mid();
        check("skip_cpu_enable", 32'(bus_a.cpu_enable), 32'd1);
        check("skip_icache_enable", 32'(bus_a.icache_enable), 32'd1);
        cyc(); bus_a.dSTRLOD = 1'b0; bus_a.dSKIP = 1'b0; bus_a.fSTALL = 1'b1;
        mid();
        check("fstall_icache_enable", 32'(bus_a.icache_enable), 32'd0);
        check("fstall_cpu_enable", 32'(bus_a.cpu_enable), 32'd1);
        check("stall_before_load", 32'(bus_a.stall_cnt), 32'd0);

        // Load on channel 1, busy for 3 cycles: 5 stalled cycles, one 2'b10 pulse.
        cyc(); bus_a.fSTALL = 1'b0; bus_a.dSTRLOD = 1'b1; bus_a.dLOD = 1'b1; bus_a.dCH_SEL = 1'b1;
        q_a.push_back('{8'h02, 1'b1});
        mid();
        check("ld_detect_cpu_enable", 32'(bus_a.cpu_enable), 32'd0);
        check("ld_detect_memop", 32'(bus_a.cpu_mode_memop), 32'd0);
        cyc(); bus_a.dcache_busy = 2'b10;
        mid();
        check("ld_req_cpu_enable", 32'(bus_a.cpu_enable), 32'd0);
        cyc(); mid();
        check("ld_wait1_memop", 32'(bus_a.cpu_mode_memop), 32'd1);
        cyc(); mid();
        check("ld_wait2_cpu_enable", 32'(bus_a.cpu_enable), 32'd0);
        cyc(); bus_a.dcache_busy = 2'b00;
        mid();
        check("ld_wait3_cpu_enable", 32'(bus_a.cpu_enable), 32'd0);
        cyc(); mid();
        check("ld_guard_cpu_enable", 32'(bus_a.cpu_enable), 32'd1);
        check("ld_guard_memop", 32'(bus_a.cpu_mode_memop), 32'd0);
        check("ld_mem_is_load", 32'(bus_a.mem_is_load), 32'd1);
        check("ld_stall_cnt", 32'(bus_a.stall_cnt), 32'd5);
        check("ld_stall_model", 32'(bus_a.stall_cnt), 32'(model_a));
        cyc(); bus_a.dSTRLOD = 1'b0; bus_a.dLOD = 1'b0; bus_a.dCH_SEL = 1'b0;
        mid();
        check("ld_after_cpu_enable", 32'(bus_a.cpu_enable), 32'd1);

        // icache_busy and a store on channel 0 together; channel-1 busy ignored.
        cyc(); bus_a.icache_busy = 1'b1; bus_a.dSTRLOD = 1'b1;
        q_a.push_back('{8'h01, 1'b0});
        mid();
        check("iw_entry_cpu_enable", 32'(bus_a.cpu_enable), 32'd0);
        check("iw_entry_icache_enable", 32'(bus_a.icache_enable), 32'd0);
        check("iw_entry_memop", 32'(bus_a.cpu_mode_memop), 32'd0);
        cyc(); mid();
        check("iw1_icache_enable", 32'(bus_a.icache_enable), 32'd0);
        cyc(); bus_a.icache_busy = 1'b0;
        mid();
        check("iw2_cpu_enable", 32'(bus_a.cpu_enable), 32'd0);
        check("iw2_memop", 32'(bus_a.cpu_mode_memop), 32'd0);
        cyc(); mid();
        check("st_detect_cpu_enable", 32'(bus_a.cpu_enable), 32'd0);
        cyc(); bus_a.dcache_busy = 2'b10;
        mid();
        check("st_req_memop", 32'(bus_a.cpu_mode_memop), 32'd1);
        cyc(); mid();
        check("st_wait_memop", 32'(bus_a.cpu_mode_memop), 32'd1);
        cyc(); bus_a.fSTALL = 1'b1;
        mid();
        check("st_guard_cpu_enable", 32'(bus_a.cpu_enable), 32'd1);
        check("st_guard_icache_enable", 32'(bus_a.icache_enable), 32'd0);
        check("st_mem_is_load", 32'(bus_a.mem_is_load), 32'd0);
        cyc(); bus_a.dSTRLOD = 1'b0; bus_a.fSTALL = 1'b0; bus_a.dcache_busy = 2'b00;
        mid();
        check("st_stall_cnt", 32'(bus_a.stall_cnt), 32'd11);
        check("st_stall_model", 32'(bus_a.stall_cnt), 32'(model_a));

        // Reset in the middle of MEM_WAIT abandons the memop.
        cyc(); bus_a.dSTRLOD = 1'b1; bus_a.dLOD = 1'b1; bus_a.dCH_SEL = 1'b1;
        q_a.push_back('{8'h02, 1'b1});
        mid();
        cyc(); bus_a.dcache_busy = 2'b11;
        mid();
        cyc(); mid();
        check("mr_wait_memop", 32'(bus_a.cpu_mode_memop), 32'd1);
        #2 rst_a = 1'b1;
        #1;
        check("mr_cpu_enable", 32'(bus_a.cpu_enable), 32'd1);
        check("mr_icache_enable", 32'(bus_a.icache_enable), 32'd1);
        check("mr_dcache_enable", 32'(bus_a.dcache_enable), 32'd0);
        check("mr_memop", 32'(bus_a.cpu_mode_memop), 32'd0);
        check("mr_mem_is_load", 32'(bus_a.mem_is_load), 32'd0);
        check("mr_stall_cnt", 32'(bus_a.stall_cnt), 32'd0);
        cyc(); bus_a.dSTRLOD = 1'b0; bus_a.dLOD = 1'b0; bus_a.dCH_SEL = 1'b0; bus_a.dcache_busy = 2'b00;
        cyc(); rst_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(); mid();
            check("mr_after_dcache_enable", 32'(bus_a.dcache_enable), 32'd0);
            check("mr_after_cpu_enable", 32'(bus_a.cpu_enable), 32'd1);
        end

        // Instance B: WAIT_W=3, icache_busy for 10 cycles -> timeout after 7 wait cycles.
        cyc(); bus_b.icache_busy = 1'b1;
        mid();
        check("to_entry_cpu_enable", 32'(bus_b.cpu_enable), 32'd0);
        for (int k = 1; k <= 9; k++) begin
            cyc(); mid();
            check($sformatf("to_wait%0d_timeout_err", k), 32'(bus_b.timeout_err), (k >= 8) ? 32'd1 : 32'd0);
        end
        cyc(); bus_b.icache_busy = 1'b0;
        mid();
        check("to_last_wait_cpu_enable", 32'(bus_b.cpu_enable), 32'd0);
        cyc(); mid();
        check("to_run_cpu_enable", 32'(bus_b.cpu_enable), 32'd1);
        check("to_sticky_timeout_err", 32'(bus_b.timeout_err), 32'd1);
        check("to_stall_cnt", 32'(bus_b.stall_cnt), 32'd11);

        // dCH_SEL=3 with NCH=3 maps to channel 0; other channels' busy ignored.
        cyc(); bus_b.dSTRLOD = 1'b1; bus_b.dLOD = 1'b1; bus_b.dCH_SEL = 2'd3;
        q_b.push_back('{8'h01, 1'b1});
        mid();
        check("oor_detect_cpu_enable", 32'(bus_b.cpu_enable), 32'd0);
        cyc(); bus_b.dcache_busy = 3'b110;
        mid();
        cyc(); mid();
        check("oor_wait_memop", 32'(bus_b.cpu_mode_memop), 32'd1);
        cyc(); mid();
        check("oor_guard_cpu_enable", 32'(bus_b.cpu_enable), 32'd1);
        check("oor_stall_cnt", 32'(bus_b.stall_cnt), 32'd14);

        // Store on channel 2; stall_cnt wraps through 16 to 1.
        cyc(); bus_b.dLOD = 1'b0; bus_b.dCH_SEL = 2'd2; bus_b.dcache_busy = 3'b000;
        q_b.push_back('{8'h04, 1'b0});
        mid();
        cyc(); mid();
        cyc(); mid();
        cyc(); bus_b.dSTRLOD = 1'b0;
        mid();
        check("ch2_guard_cpu_enable", 32'(bus_b.cpu_enable), 32'd1);
        check("ch2_mem_is_load", 32'(bus_b.mem_is_load), 32'd0);
        check("ch2_timeout_still_set", 32'(bus_b.timeout_err), 32'd1);
        check("wrap_stall_cnt", 32'(bus_b.stall_cnt), 32'd1);
        check("wrap_stall_model", 32'(bus_b.stall_cnt), 32'(model_b % 16));

        cyc(); rst_b = 1'b1;
        mid();
        check("to_cleared_by_reset", 32'(bus_b.timeout_err), 32'd0);
        cyc(); rst_b = 1'b0;

        cyc(); mid();
        check("a_queue_drained", 32'(q_a.size()), 32'd0);
        check("b_queue_drained", 32'(q_b.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aexm_enable_nport.md
AEXM_ENABLE_NPORT -- requirements
Module: aexm_enable_nport

Interface
REQ-001 SHALL have parameter NCH, default 2, meaning number of data-cache channels (1..8).
REQ-002 SHALL have parameter WAIT_W, default 8, meaning width of the busy-timeout counter.
REQ-003 SHALL have parameter CNT_W, default 16, meaning width of the stall-cycle counter.
REQ-004 SHALL have port gclk  input  1  clock, all state on rising edge.
REQ-005 SHALL have port grst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port icache_busy  input  1  instruction cache busy.
REQ-007 SHALL have port dcache_busy  input  NCH  per-channel data cache busy.
REQ-008 SHALL have port dSTRLOD  input  1  decode-stage instruction is a load or store.
REQ-009 SHALL have port dLOD  input  1  decode-stage memop is a load.
REQ-010 SHALL have port dSKIP  input  1  decode-stage instruction is annulled.
REQ-011 SHALL have port fSTALL  input  1  fetch hold request from control.
REQ-012 SHALL have port dCH_SEL  input  max(1,clog2(NCH))  target data channel of the memop.
REQ-013 SHALL have port cpu_enable  output  1  pipeline advance enable.
REQ-014 SHALL have port icache_enable  output  1  instruction cache precycle enable.
REQ-015 SHALL have port dcache_enable  output  NCH  one-hot data cache precycle enable.
REQ-016 SHALL have port cpu_mode_memop  output  1  memop in progress.
REQ-017 SHALL have port mem_is_load  output  1  latched dLOD of the current memop.
REQ-018 SHALL have port timeout_err  output  1  sticky busy-timeout flag.
REQ-019 SHALL have port stall_cnt  output  CNT_W  count of cycles with cpu_enable low.

Function
REQ-020 SHALL implement FSM states RUN, I_WAIT, MEM_REQ, MEM_WAIT.
REQ-021 In RUN with icache_busy=1, SHALL go to I_WAIT and drive cpu_enable=0 combinationally in that same cycle.
REQ-022 In RUN with icache_busy=0, dSTRLOD=1, dSKIP=0, SHALL latch dCH_SEL and dLOD, drive cpu_enable=0, and go to MEM_REQ.
REQ-023 In RUN otherwise, SHALL drive cpu_enable=1 and icache_enable=!fSTALL.
REQ-024 In I_WAIT, SHALL drive cpu_enable=0 and icache_enable=0, and return to RUN on the first cycle with icache_busy=0.
REQ-025 In MEM_REQ, SHALL assert dcache_enable for exactly one cycle on the latched channel only, with cpu_mode_memop=1, then go to MEM_WAIT.
REQ-026 In MEM_WAIT, SHALL hold cpu_mode_memop=1 and cpu_enable=0, and go to RUN on the first cycle in which dcache_busy[latched channel]=0; busy on other channels SHALL be ignored.
REQ-027 The first RUN cycle after MEM_WAIT SHALL assert cpu_enable=1 and SHALL NOT re-detect the same memop, via a one-cycle post-memop guard.
REQ-028 A dCH_SEL value >= NCH SHALL select channel 0.
REQ-029 When icache_busy and dSTRLOD occur together in RUN, I_WAIT SHALL take priority; the held memop SHALL be recognised on the return to RUN.
REQ-030 A wait counter of WAIT_W bits SHALL clear on entry to I_WAIT or MEM_WAIT, increment each wait cycle, and saturate at all-ones.
REQ-031 Reaching saturation SHALL set timeout_err, which stays set until reset; the FSM SHALL keep waiting.
REQ-032 stall_cnt SHALL increment every cycle with cpu_enable=0 and wrap modulo 2^CNT_W.
REQ-033 mem_is_load SHALL hold its latched value from MEM_REQ until the next memop latch.

Reset
REQ-034 grst=1 SHALL asynchronously force RUN, cpu_enable=1, icache_enable=1, dcache_enable=0, cpu_mode_memop=0, mem_is_load=0, timeout_err=0, stall_cnt=0, wait counter=0, guard=0.
REQ-035 Reset during MEM_REQ or MEM_WAIT SHALL abandon the memop with no further dcache_enable pulse.

Structure
REQ-036 State encoding and the default values of NCH, WAIT_W and CNT_W SHALL live in shared package aexm_pkg.
REQ-037 The saturating wait counter SHALL be sub-module aexm_sat_counter (parameter width; clear, inc, sat outputs).

Verification
REQ-038 NCH=2, dSTRLOD=1, dLOD=1, dCH_SEL=1, dcache_busy[1] high for 3 cycles -> exactly one dcache_enable=2'b10 pulse; cpu_enable low for 5 cycles; mem_is_load=1; stall_cnt=5.
REQ-039 icache_busy and dSTRLOD rise together, icache_busy held 2 cycles -> I_WAIT for 2 cycles, then MEM_REQ; dcache_enable pulses once.
REQ-040 MEM_WAIT on channel 0 while dcache_busy=2'b10 -> return to RUN next cycle; the channel-1 busy is ignored.
REQ-041 WAIT_W=3, icache_busy held 10 cycles -> timeout_err set after the 7th wait cycle; it stays set after icache_busy drops, until grst.
REQ-042 grst pulsed mid MEM_WAIT -> all outputs at reset values immediately, with no dcache_enable pulse afterwards.
REQ-043 dCH_SEL=3 with NCH=3 -> dcache_enable=3'b001.
